// File: rtl/pipeline_if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional misaligned-redirect trap is enabled by defining IF_MISALIGN_TRAP_EN.
package pipeline_if_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StDrop  = 2'd2
    } if_state_e;

    localparam logic [31:0]  NOP_INSTR           = 32'h0000_0013;
    localparam int unsigned  DEFAULT_XLEN        = 32;
    localparam logic [31:0]  DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam int unsigned  DEFAULT_INSTR_BYTES = 4;

endpackage

// File: rtl/pipeline_if_fetch_buf.sv
// One-entry IF/ID output buffer with load, flush and drain (load has priority).
// Carries an exception flag when IF_MISALIGN_TRAP_EN is defined.
module if_out_buf
    import pipeline_if_pkg::*;
#(
    parameter int unsigned Width = DEFAULT_XLEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             drain_i,
    input  logic [Width-1:0] load_pc_i,
    input  logic [Width-1:0] load_instr_i,
`ifdef IF_MISALIGN_TRAP_EN
    input  logic             load_exc_i,
    output logic             exc_o,
`endif
    output logic             valid_o,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] instr_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] pc_d, pc_q;
    logic [Width-1:0] instr_d, instr_q;
`ifdef IF_MISALIGN_TRAP_EN
    logic             exc_d, exc_q;
`endif

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IF_MISALIGN_TRAP_EN
        exc_d   = exc_q;
`endif
        if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            instr_d = load_instr_i;
`ifdef IF_MISALIGN_TRAP_EN
            exc_d   = load_exc_i;
`endif
        end else if (flush_i || drain_i) begin
            valid_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            exc_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef IF_MISALIGN_TRAP_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign exc_o   = exc_q;
`endif

endmodule

// File: rtl/pipeline_if_fetch.sv
// Instruction-fetch stage: PC, redirect handling, single-outstanding imem handshake, IF/ID buffer.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of masking them.
module pipeline_if_fetch
    import pipeline_if_pkg::*;
#(
    parameter int unsigned      XLEN        = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned      INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic            clk_IF,
    input  logic            rst_IF,
    input  logic            en_IF,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PC_in_IF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            if_exc,
`endif
    output logic [XLEN-1:0] PC_out_IF
);

    localparam logic [XLEN-1:0] OFF_MASK = XLEN'(INSTR_BYTES - 1);

    if_state_e       state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] req_pc_d, req_pc_q;
    logic [XLEN-1:0] target;
    logic            buf_load, buf_flush, buf_drain;
    logic [XLEN-1:0] load_pc, load_instr;
`ifdef IF_MISALIGN_TRAP_EN
    logic            misaligned;
    logic            load_exc;
    logic            park_d, park_q;

    assign target     = PC_in_IF;
    assign misaligned = |(PC_in_IF & OFF_MASK);
`else
    assign target     = PC_in_IF & ~OFF_MASK;
`endif

    // Issue only when the buffer is guaranteed empty by the time the response lands.
    always_comb begin
        imem_req = rst_IF && (state_q == StFetch) && en_IF && !PCSrc && (!if_valid || id_ready);
`ifdef IF_MISALIGN_TRAP_EN
        if (park_q) imem_req = 1'b0;
`endif
    end

    assign imem_addr = pc_q;
    assign PC_out_IF = pc_q;
    assign buf_drain = if_valid && id_ready && en_IF;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        load_pc    = req_pc_q;
        load_instr = imem_rdata;

        unique case (state_q)
            StFetch: begin
                if (PCSrc) begin
                    pc_d      = target;
                    buf_flush = 1'b1;
                end else if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (PCSrc) begin
                    pc_d      = target;
                    buf_flush = 1'b1;
                    state_d   = imem_rvalid ? StFetch : StDrop;
                end else if (imem_rvalid) begin
                    buf_load = 1'b1;
                    pc_d     = req_pc_q + XLEN'(INSTR_BYTES);
                    state_d  = StFetch;
                end
            end
            StDrop: begin
                if (PCSrc) begin
                    pc_d      = target;
                    buf_flush = 1'b1;
                end
                if (imem_rvalid) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

`ifdef IF_MISALIGN_TRAP_EN
        load_exc = 1'b0;
        park_d   = PCSrc ? misaligned : park_q;
        // A misaligned target is reported through the buffer rather than fetched.
        if (PCSrc && misaligned) begin
            buf_flush  = 1'b0;
            buf_load   = 1'b1;
            load_pc    = PC_in_IF;
            load_instr = XLEN'(NOP_INSTR);
            load_exc   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_IF or negedge rst_IF) begin
        if (!rst_IF) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
`ifdef IF_MISALIGN_TRAP_EN
            park_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
`ifdef IF_MISALIGN_TRAP_EN
            park_q   <= park_d;
`endif
        end
    end

    if_out_buf #(
        .Width (XLEN)
    ) u_out_buf (
        .clk_i        (clk_IF),
        .rst_ni       (rst_IF),
        .load_i       (buf_load),
        .flush_i      (buf_flush),
        .drain_i      (buf_drain),
        .load_pc_i    (load_pc),
        .load_instr_i (load_instr),
`ifdef IF_MISALIGN_TRAP_EN
        .load_exc_i   (load_exc),
        .exc_o        (if_exc),
`endif
        .valid_o      (if_valid),
        .pc_o         (if_pc),
        .instr_o      (if_instr)
    );

endmodule

// File: tb/tb_pipeline_if_fetch.sv
// Directed bench for pipeline_if_fetch: default instance plus a RESET_PC wrap instance.
// Builds with or without IF_MISALIGN_TRAP_EN (only the default behaviour is checked).
module tb_pipeline_if_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_IF, PCSrc, id_ready;
    logic [31:0] PC_in_IF;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, PC_out_IF;

    logic        w_req, w_gnt, w_rvalid;
    logic [31:0] w_addr, w_rdata;
    logic        w_valid;
    logic [31:0] w_pc, w_instr, w_pc_out;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_exc, w_exc;
`endif

    assign imem_gnt = imem_req;
    assign w_gnt    = w_req;

    pipeline_if_fetch u_dut (
        .clk_IF      (clk),
        .rst_IF      (rst_n),
        .en_IF       (en_IF),
        .PCSrc       (PCSrc),
        .PC_in_IF    (PC_in_IF),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
`ifdef IF_MISALIGN_TRAP_EN
        .if_exc      (if_exc),
`endif
        .PC_out_IF   (PC_out_IF)
    );

    pipeline_if_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk_IF      (clk),
        .rst_IF      (rst_n),
        .en_IF       (1'b1),
        .PCSrc       (1'b0),
        .PC_in_IF    (32'h0),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_gnt    (w_gnt),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .id_ready    (1'b1),
        .if_valid    (w_valid),
        .if_pc       (w_pc),
        .if_instr    (w_instr),
`ifdef IF_MISALIGN_TRAP_EN
        .if_exc      (w_exc),
`endif
        .PC_out_IF   (w_pc_out)
    );

    int          n_checks = 0;
    int          n_bad    = 0;
    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Advance one clock; memory model answers 'lat' cycles after grant, one-shot rvalid.
    task automatic tick();
        logic        acc, cons, wacc, wcons;
        logic [31:0] aaddr, waddr;
        acc   = imem_req && imem_gnt;
        aaddr = imem_addr;
        cons  = imem_rvalid;
        wacc  = w_req && w_gnt;
        waddr = w_addr;
        wcons = w_rvalid;
        @(posedge clk);
        #1;
        if (cons) imem_rvalid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = aaddr;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend        = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(paddr);
            end
        end
        if (wcons) w_rvalid = 1'b0;
        if (wacc) begin
            w_rvalid = 1'b1;
            w_rdata  = instr_of(waddr);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en_IF       = 1'b1;
        PCSrc       = 1'b0;
        PC_in_IF    = 32'h0;
        id_ready    = 1'b1;
        lat         = 1;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        // Reset state and steady-state sequential fetch
        do_reset();
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_pc", if_pc, 0);
        check_eq("rst_instr", if_instr, 0);
        check_eq("rst_pcout", PC_out_IF, 32'h0);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_wrap_pcout", w_pc_out, 32'hFFFF_FFFC);
        release_reset();
        check_eq("seq_req0", imem_req, 1);
        check_eq("seq_addr0", imem_addr, 32'h0);
        tick();
        check_eq("seq_wait_req", imem_req, 0);
        check_eq("seq_wait_valid", if_valid, 0);
        tick();
        check_eq("seq_v0", if_valid, 1);
        check_eq("seq_pc0", if_pc, 32'h0);
        check_eq("seq_instr0", if_instr, 32'hDEAD_0000);
        check_eq("seq_addr4", imem_addr, 32'h4);
        check_eq("seq_pcout4", PC_out_IF, 32'h4);
        tick();
        check_eq("seq_drain", if_valid, 0);
        tick();
        check_eq("seq_v4", if_valid, 1);
        check_eq("seq_pc4", if_pc, 32'h4);
        check_eq("seq_instr4", if_instr, 32'hDEAD_0004);
        check_eq("seq_addr8", imem_addr, 32'h8);
        tick();
        tick();
        check_eq("seq_pc8", if_pc, 32'h8);
        check_eq("seq_instr8", if_instr, 32'hDEAD_0008);
        check_eq("seq_addrC", imem_addr, 32'hC);

        // Back-pressure from ID, then redirect in FETCH with masked target
        do_reset();
        id_ready = 1'b0;
        release_reset();
        check_eq("bp_req0", imem_req, 1);
        tick();
        tick();
        check_eq("bp_loaded", if_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", if_valid, 1);
            check_eq("bp_hold_pc", if_pc, 32'h0);
            check_eq("bp_hold_req", imem_req, 0);
            tick();
        end
        id_ready = 1'b1;
        #1;
        check_eq("bp_resume_req", imem_req, 1);
        check_eq("bp_resume_addr", imem_addr, 32'h4);
        PCSrc    = 1'b1;
        PC_in_IF = 32'h303;
        #1;
        check_eq("rf_req_suppr", imem_req, 0);
        tick();
        PCSrc = 1'b0;
        #1;
        check_eq("rf_flush", if_valid, 0);
        check_eq("rf_masked_pc", PC_out_IF, 32'h300);
        check_eq("rf_req", imem_req, 1);
        check_eq("rf_addr", imem_addr, 32'h300);

        // Redirect while waiting; late response must be dropped
        do_reset();
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        check_eq("dr_addr8", imem_addr, 32'h8);
        lat = 3;
        tick();
        PCSrc    = 1'b1;
        PC_in_IF = 32'h100;
        tick();
        PCSrc = 1'b0;
        #1;
        check_eq("dr_valid", if_valid, 0);
        check_eq("dr_pcout", PC_out_IF, 32'h100);
        check_eq("dr_req_drop", imem_req, 0);
        tick();
        check_eq("dr_rvalid_req", imem_req, 0);
        tick();
        check_eq("dr_no_load", if_valid, 0);
        check_eq("dr_req", imem_req, 1);
        check_eq("dr_addr", imem_addr, 32'h100);
        lat = 1;
        tick();
        tick();
        check_eq("dr_v", if_valid, 1);
        check_eq("dr_pc", if_pc, 32'h100);
        check_eq("dr_instr", if_instr, 32'hDEAD_0100);

        // Redirect coinciding with rvalid
        do_reset();
        release_reset();
        tick();
        PCSrc    = 1'b1;
        PC_in_IF = 32'h202;
        tick();
        PCSrc = 1'b0;
        #1;
        check_eq("co_valid", if_valid, 0);
        check_eq("co_pcout", PC_out_IF, 32'h200);
        check_eq("co_req", imem_req, 1);
        check_eq("co_addr", imem_addr, 32'h200);
        tick();
        tick();
        check_eq("co_v", if_valid, 1);
        check_eq("co_pc", if_pc, 32'h200);
        check_eq("co_instr", if_instr, 32'hDEAD_0200);

        // Stall with a request outstanding
        do_reset();
        lat = 3;
        release_reset();
        check_eq("st_req", imem_req, 1);
        tick();
        en_IF = 1'b0;
        tick();
        tick();
        tick();
        check_eq("st_valid", if_valid, 1);
        check_eq("st_pc", if_pc, 32'h0);
        check_eq("st_instr", if_instr, 32'hDEAD_0000);
        check_eq("st_pcout", PC_out_IF, 32'h4);
        check_eq("st_req_off", imem_req, 0);
        tick();
        check_eq("st_hold", if_valid, 1);
        check_eq("st_hold_req", imem_req, 0);
        en_IF = 1'b1;
        #1;
        check_eq("st_resume_req", imem_req, 1);
        check_eq("st_resume_addr", imem_addr, 32'h4);

        // PC wrap and reset mid-WAIT
        do_reset();
        release_reset();
        check_eq("wr_addr0", w_addr, 32'hFFFF_FFFC);
        check_eq("wr_req0", w_req, 1);
        tick();
        tick();
        check_eq("wr_valid", w_valid, 1);
        check_eq("wr_pc", w_pc, 32'hFFFF_FFFC);
        check_eq("wr_instr", w_instr, 32'h2152_FFFC);
        check_eq("wr_addr_wrap", w_addr, 32'h0);
        tick();
        check_eq("wr_wait_req", w_req, 0);
        rst_n = 1'b0;
        #1;
        check_eq("ar_wrap_valid", w_valid, 0);
        check_eq("ar_wrap_pcout", w_pc_out, 32'hFFFF_FFFC);
        check_eq("ar_wrap_ifpc", w_pc, 32'h0);
        check_eq("ar_main_pcout", PC_out_IF, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_if_fetch.md
Name: pipeline_if_fetch

Overview:
- Parametrised instruction-fetch stage: PC register, sequential/redirect next-PC selection, request/response handshake to instruction memory, one-entry output buffer toward ID.
- Adds stall, flush-on-redirect and stale-response dropping.
- Sits between the branch-resolution logic (PCSrc/PC_in_IF) and the IF/ID boundary.

Parameters:
- XLEN, 32, width of PC, address and instruction data.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INSTR_BYTES, 4, sequential PC increment; power of two.

Ports:
- clk_IF  in  1  clock, rising edge.
- rst_IF  in  1  reset, asynchronous, active-low.
- en_IF  in  1  stage enable; 0 = stall (no new request, PC and buffer held).
- PCSrc  in  1  redirect strobe; acts regardless of en_IF.
- PC_in_IF  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc_q).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; in order, at least 1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- id_ready  in  1  ID accepts the buffer this cycle.
- if_valid  out  1  buffer holds a valid instruction.
- if_pc  out  XLEN  PC of buffered instruction.
- if_instr  out  XLEN  buffered instruction.
- PC_out_IF  out  XLEN  current fetch PC, pc_q.

Behaviour:
- Reset (rst_IF low): pc_q=RESET_PC; state=FETCH; if_valid=0; if_pc=0; if_instr=0; imem_req forced 0 while reset is asserted.
- States:
  - FETCH: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- Request rule: imem_req = (state==FETCH) && en_IF && !PCSrc && (!if_valid || id_ready). At most one request is outstanding.
- FETCH, on imem_req && imem_gnt: req_pc<=pc_q; go WAIT.
- WAIT, on imem_rvalid with no PCSrc:
  - if_valid<=1, if_pc<=req_pc, if_instr<=imem_rdata.
  - pc_q<=req_pc+INSTR_BYTES, modulo 2^XLEN (wraps).
  - Go FETCH.
- WAIT ignores en_IF. The response is always captured, because issue guaranteed the buffer would be empty.
- Buffer drain: if_valid && id_ready && en_IF with no new load: if_valid<=0. Load and drain in the same cycle: the new entry replaces the old one.
- en_IF=0: buffer held even if id_ready=1.
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect (PCSrc=1) has highest priority:
  - pc_q<=PC_in_IF; if_valid<=0.
  - In WAIT without rvalid: go DROP.
  - In WAIT with rvalid the same cycle: response discarded, go FETCH.
  - In FETCH: stay FETCH; no request is issued that cycle.
- DROP:
  - On imem_rvalid: discard data, go FETCH.
  - On PCSrc: pc_q updates; stays DROP unless rvalid arrives the same cycle.
- A back-to-back redirect overwrites pc_q; the last target wins.
- Async reset mid-WAIT/DROP returns to FETCH. The memory side is reset by the same signal, so no stale response is expected.

Optional Feature:
- IF_MISALIGN_TRAP_EN.
- Defined:
  - Output if_exc (1 bit, reset 0) is added.
  - A redirect target with PC_in_IF[log2(INSTR_BYTES)-1:0]!=0 issues no fetch and loads the buffer: if_valid=1, if_pc=target, if_instr=32'h0000_0013 (NOP), if_exc=1.
  - The stage then parks in FETCH with requests suppressed until the next PCSrc.
- Undefined: target low bits are masked to zero before loading pc_q; no if_exc port exists.

Decomposition:
- Package pipeline_if_pkg holds:
  - State enum {FETCH, WAIT, DROP}.
  - NOP_INSTR constant.
  - Default values for XLEN, RESET_PC and INSTR_BYTES.
- One sub-module, if_out_buf: parametrised one-entry buffer with load/drain/flush and valid, holding if_pc/if_instr (plus if_exc when the macro is defined).

Test Plan:
- Reset release, 1-cycle memory, id_ready=1, en_IF=1 -> imem_addr sequence 0,4,8,C; if_pc 0,4,8 each with the matching if_instr; if_valid pulses every 2nd cycle.
- id_ready=0 for 5 cycles after first load -> if_valid stays 1 with if_pc=0; no imem_req while full; fetch of 4 issues the cycle id_ready returns.
- PCSrc=1, PC_in_IF=0x100 while in WAIT for addr 8, rvalid 2 cycles later -> that response dropped, if_valid=0, next imem_addr=0x100, then if_pc=0x100.
- PCSrc and imem_rvalid in the same WAIT cycle -> data discarded; the next request is to the target.
- en_IF=0 for 3 cycles with a request outstanding -> response captured; no new request; if_valid held; PC_out_IF=req_pc+4.
- RESET_PC=32'hFFFF_FFFC -> second fetch address wraps to 0x0000_0000. Reset asserted mid-WAIT -> if_valid=0, PC_out_IF=RESET_PC immediately.
